// File: rtl/byte_striper_n.sv
`default_nettype none
// ============================================================================
// Module      : byte_striper_n
// Description : N-lane byte striper; round-robin word distribution with
//               FREE slot rotation or ALIGN (lane-0 aligned, flushing) mode.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_striper_n #(
    parameter int DATA_W     = 8,
    parameter int LANES      = 4,
    parameter int ALIGN_MODE = 0
) (
    input  logic                    clk_nf,
    input  logic                    reset_L,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    valid_in,
    output logic [LANES*DATA_W-1:0] data_stripe,
    output logic [LANES-1:0]        valid_stripe,
    output logic                    stripe_strobe,
    output logic                    stripe_partial
);

    localparam int                 c_PTR_W = $clog2(LANES);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(LANES - 1);
    localparam logic [c_PTR_W-1:0] c_ONE   = c_PTR_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_PTR_W-1:0]      r_ptr;
    logic [c_PTR_W-1:0]      w_ptr_nxt;
    logic [DATA_W-1:0]       r_shadow [LANES];
    logic [LANES-1:0]        r_shadow_vld;
    logic                    w_store;
    logic                    w_emit;
    logic                    w_partial;
    logic [DATA_W-1:0]       w_word;
    logic [LANES*DATA_W-1:0] w_group_data;
    logic [LANES-1:0]        w_group_vld;

    logic [LANES*DATA_W-1:0] r_data_stripe;
    logic [LANES-1:0]        r_valid_stripe;
    logic                    r_strobe;
    logic                    r_partial;

    // Invalid words are stored as zero so unfilled lanes never leak stale data.
    assign w_word = valid_in ? data_in : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_store     = 1'b0;
        w_emit      = 1'b0;
        w_partial   = 1'b0;
        if (ALIGN_MODE == 0) begin
            w_state_nxt = S_IDLE;
            if (r_ptr == c_LAST) begin
                w_emit    = 1'b1;
                w_ptr_nxt = '0;
            end else begin
                w_store   = 1'b1;
                w_ptr_nxt = r_ptr + 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        w_store     = 1'b1;
                        w_ptr_nxt   = c_ONE;
                        w_state_nxt = S_FILL;
                    end
                end
                S_FILL: begin
                    if (valid_in && (r_ptr != c_LAST)) begin
                        w_store   = 1'b1;
                        w_ptr_nxt = r_ptr + 1'b1;
                    end else begin
                        // Either the last lane arrived or the stream went idle.
                        w_emit      = 1'b1;
                        w_partial   = ~valid_in;
                        w_ptr_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
            endcase
        end
    end

    // Group seen at an emit edge: shadow lanes plus the word arriving now.
    always_comb begin
        w_group_data = '0;
        w_group_vld  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_ptr == c_PTR_W'(i)) begin
                w_group_data[i*DATA_W +: DATA_W] = w_word;
                w_group_vld[i]                   = valid_in;
            end else if (r_shadow_vld[i]) begin
                w_group_data[i*DATA_W +: DATA_W] = r_shadow[i];
                w_group_vld[i]                   = 1'b1;
            end
        end
    end

    // reset_L release is expected to be synchronised to clk_nf upstream.
    always_ff @(posedge clk_nf or negedge reset_L) begin
        if (!reset_L) begin
            r_state        <= S_IDLE;
            r_ptr          <= '0;
            r_shadow_vld   <= '0;
            r_data_stripe  <= '0;
            r_valid_stripe <= '0;
            r_strobe       <= 1'b0;
            r_partial      <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_strobe  <= w_emit;
            r_partial <= w_partial;
            if (w_emit) begin
                r_data_stripe  <= w_group_data;
                r_valid_stripe <= w_group_vld;
                r_shadow_vld   <= '0;
            end else if (w_store) begin
                r_shadow[r_ptr]     <= w_word;
                r_shadow_vld[r_ptr] <= valid_in;
            end
        end
    end

    assign data_stripe    = r_data_stripe;
    assign valid_stripe   = r_valid_stripe;
    assign stripe_strobe  = r_strobe;
    assign stripe_partial = r_partial;

endmodule
`default_nettype wire

// File: tb/tb_byte_striper_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_striper_n
// Description : Directed self-checking bench for byte_striper_n (FREE + ALIGN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_striper_n;

    logic        clk_nf = 1'b0;
    logic        reset_L;
    logic [7:0]  data_in;
    logic        valid_in;

    logic [31:0] w_free_data;
    logic [3:0]  w_free_vld;
    logic        w_free_stb;
    logic        w_free_part;
    logic [31:0] w_align_data;
    logic [3:0]  w_align_vld;
    logic        w_align_stb;
    logic        w_align_part;

    int errors = 0;
    int checks = 0;

    always #5 clk_nf = ~clk_nf;

    byte_striper_n #(.DATA_W(8), .LANES(4), .ALIGN_MODE(0)) u_free (
        .clk_nf         (clk_nf),
        .reset_L        (reset_L),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .data_stripe    (w_free_data),
        .valid_stripe   (w_free_vld),
        .stripe_strobe  (w_free_stb),
        .stripe_partial (w_free_part)
    );

    byte_striper_n #(.DATA_W(8), .LANES(4), .ALIGN_MODE(1)) u_align (
        .clk_nf         (clk_nf),
        .reset_L        (reset_L),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .data_stripe    (w_align_data),
        .valid_stripe   (w_align_vld),
        .stripe_strobe  (w_align_stb),
        .stripe_partial (w_align_part)
    );

    task automatic step(input logic [7:0] d, input logic v);
        data_in  = d;
        valid_in = v;
        @(posedge clk_nf);
        #1;
    endtask

    task automatic apply_reset();
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        @(posedge clk_nf);
        @(posedge clk_nf);
        #1;
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(8'($urandom), 1'($urandom));
            checks++;
            if ({w_free_data, w_free_vld, w_free_stb, w_free_part} !== 38'h0) begin
                errors++;
                $display("FAIL reset_free cyc%0d: got %h/%b/%b/%b want 0", c,
                         w_free_data, w_free_vld, w_free_stb, w_free_part);
            end
            checks++;
            if ({w_align_data, w_align_vld, w_align_stb, w_align_part} !== 38'h0) begin
                errors++;
                $display("FAIL reset_align cyc%0d: got %h/%b/%b/%b want 0", c,
                         w_align_data, w_align_vld, w_align_stb, w_align_part);
            end
        end
        reset_L = 1'b1;
    endtask

    task automatic test_free_stream();
        logic        exp_stb;
        logic [31:0] exp_data;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            step(8'(16 + k), 1'b1);
            exp_stb  = ((k % 4) == 3);
            exp_data = (k < 4) ? 32'h13121110 : 32'h17161514;
            checks++;
            if (w_free_stb !== exp_stb) begin
                errors++;
                $display("FAIL free_stream_stb k=%0d: got %b want %b", k, w_free_stb, exp_stb);
            end
            if (exp_stb) begin
                checks++;
                if ({w_free_data, w_free_vld, w_free_part} !== {exp_data, 4'hF, 1'b0}) begin
                    errors++;
                    $display("FAIL free_stream_grp k=%0d: got %h/%h/%b want %h/f/0", k,
                             w_free_data, w_free_vld, w_free_part, exp_data);
                end
            end
        end
    endtask

    task automatic test_free_invalid_slot();
        logic [7:0] d [4];
        logic       v [4];
        d = '{8'h20, 8'h55, 8'h22, 8'h23};
        v = '{1'b1, 1'b0, 1'b1, 1'b1};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            step(d[k], v[k]);
            checks++;
            if (w_free_stb !== (k == 3)) begin
                errors++;
                $display("FAIL free_gap_stb k=%0d: got %b want %b", k, w_free_stb, (k == 3));
            end
        end
        checks++;
        if ({w_free_data, w_free_vld, w_free_part} !== {32'h23220020, 4'b1101, 1'b0}) begin
            errors++;
            $display("FAIL free_gap_grp: got %h/%b/%b want 23220020/1101/0",
                     w_free_data, w_free_vld, w_free_part);
        end
        for (int k = 0; k < 4; k++) begin
            step(8'h77, 1'b0);
        end
        checks++;
        if ({w_free_stb, w_free_data, w_free_vld} !== {1'b1, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL free_empty_grp: got %b/%h/%b want 1/00000000/0000",
                     w_free_stb, w_free_data, w_free_vld);
        end
    endtask

    task automatic test_align_flush();
        apply_reset();
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        checks++;
        if (w_align_stb !== 1'b0) begin
            errors++;
            $display("FAIL align_idle_stb: got %b want 0", w_align_stb);
        end
        for (int k = 0; k < 3; k++) begin
            step(8'(8'hA0 + k), 1'b1);
            checks++;
            if (w_align_stb !== 1'b0) begin
                errors++;
                $display("FAIL align_fill_stb k=%0d: got %b want 0", k, w_align_stb);
            end
        end
        step(8'h00, 1'b0);
        checks++;
        if ({w_align_stb, w_align_part, w_align_data, w_align_vld} !==
            {1'b1, 1'b1, 32'h00A2A1A0, 4'b0111}) begin
            errors++;
            $display("FAIL align_flush: got %b/%b/%h/%b want 1/1/00a2a1a0/0111",
                     w_align_stb, w_align_part, w_align_data, w_align_vld);
        end
        step(8'h00, 1'b0);
        checks++;
        if (w_align_stb !== 1'b0) begin
            errors++;
            $display("FAIL align_after_flush_stb: got %b want 0", w_align_stb);
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_stb;
        logic [31:0] exp_data;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            step((k < 4) ? 8'(8'hB0 + k) : 8'(8'hC0 + k - 4), 1'b1);
            exp_stb  = ((k % 4) == 3);
            exp_data = (k < 4) ? 32'hB3B2B1B0 : 32'hC3C2C1C0;
            checks++;
            if (w_align_stb !== exp_stb) begin
                errors++;
                $display("FAIL b2b_stb k=%0d: got %b want %b", k, w_align_stb, exp_stb);
            end
            if (exp_stb) begin
                checks++;
                if ({w_align_data, w_align_vld, w_align_part} !== {exp_data, 4'hF, 1'b0}) begin
                    errors++;
                    $display("FAIL b2b_grp k=%0d: got %h/%h/%b want %h/f/0", k,
                             w_align_data, w_align_vld, w_align_part, exp_data);
                end
            end
        end
        step(8'h00, 1'b0);
        checks++;
        if (w_align_stb !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_stb: got %b want 0", w_align_stb);
        end
    endtask

    task automatic test_toggle();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            step(8'(8'h50 + k), 1'b1);
            checks++;
            if (w_align_stb !== 1'b0) begin
                errors++;
                $display("FAIL toggle_valid_stb k=%0d: got %b want 0", k, w_align_stb);
            end
            step(8'h00, 1'b0);
            checks++;
            if ({w_align_stb, w_align_part, w_align_data, w_align_vld} !==
                {1'b1, 1'b1, 32'(8'h50 + k), 4'b0001}) begin
                errors++;
                $display("FAIL toggle_flush k=%0d: got %b/%b/%h/%b want 1/1/%h/0001", k,
                         w_align_stb, w_align_part, w_align_data, w_align_vld, 32'(8'h50 + k));
            end
        end
    endtask

    task automatic test_reset_mid_group();
        apply_reset();
        step(8'hE0, 1'b1);
        step(8'hE1, 1'b1);
        reset_L = 1'b0;
        #1;
        checks++;
        if ({w_align_stb, w_align_part, w_align_data, w_align_vld} !== 38'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got %b/%b/%h/%b want all 0",
                     w_align_stb, w_align_part, w_align_data, w_align_vld);
        end
        @(posedge clk_nf);
        #1;
        reset_L = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(8'(8'hD0 + k), 1'b1);
            checks++;
            if (w_align_stb !== (k == 3)) begin
                errors++;
                $display("FAIL midrst_stb k=%0d: got %b want %b", k, w_align_stb, (k == 3));
            end
        end
        checks++;
        if ({w_align_data, w_align_vld, w_align_part} !== {32'hD3D2D1D0, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL midrst_grp: got %h/%h/%b want d3d2d1d0/f/0",
                     w_align_data, w_align_vld, w_align_part);
        end
    endtask

    initial begin
        reset_L  = 1'b1;
        data_in  = 8'h00;
        valid_in = 1'b0;
        #2;
        test_reset();
        test_free_stream();
        test_free_invalid_slot();
        test_align_flush();
        test_back_to_back();
        test_toggle();
        test_reset_mid_group();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
